// File: rtl/key_input_pio.sv
// Avalon-MM input PIO: synchronizes, debounces and edge-captures WIDTH board pins,
// with a maskable level interrupt on captured rising edges.
module key_input_pio #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins_in,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_IRQMASK = 2'd1,
        REG_EDGECAP = 2'd2,
        REG_RAW     = 2'd3
    } reg_addr_e;

    logic [WIDTH-1:0] sync1, sync2;
    logic [WIDTH-1:0] stable, stable_nxt;
    logic [WIDTH-1:0] edgecap, edgecap_nxt;
    logic [WIDTH-1:0] irqmask, irqmask_nxt;
    logic [WIDTH-1:0] clr_mask;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [31:0]      readdata_nxt;
    logic             rd_en, wr_en;
    reg_addr_e        addr;
    logic             unused_writedata;

    assign rd_en            = chipselect & read;
    assign wr_en            = chipselect & write;
    assign addr             = reg_addr_e'(address);
    assign unused_writedata = ^writedata;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) stable_nxt[i] = sync2[i];
                else                    cnt_nxt[i]    = cnt[i] + 1'b1;
            end
        end
    end

    // A rising edge on the same clock as a W1C of that bit keeps the bit set.
    always_comb begin
        clr_mask    = (wr_en && addr == REG_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        edgecap_nxt = (edgecap & ~clr_mask) | (stable_nxt & ~stable);
        irqmask_nxt = (wr_en && addr == REG_IRQMASK) ? writedata[WIDTH-1:0] : irqmask;
    end

    // Read data is taken from pre-edge register values, so a same-cycle write is not visible.
    always_comb begin
        readdata_nxt = '0;
        if (rd_en) begin
            unique case (addr)
                REG_DATA:    readdata_nxt = 32'(stable);
                REG_IRQMASK: readdata_nxt = 32'(irqmask);
                REG_EDGECAP: readdata_nxt = 32'(edgecap);
                REG_RAW:     readdata_nxt = 32'(sync2);
            endcase
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            edgecap  <= '0;
            irqmask  <= '0;
            readdata <= '0;
            // NOTE: the counter array is per-bit control state, not RAM, so each entry is reset explicitly.
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            sync1    <= pins_in;
            sync2    <= sync1;
            stable   <= stable_nxt;
            edgecap  <= edgecap_nxt;
            irqmask  <= irqmask_nxt;
            readdata <= readdata_nxt;
            cnt      <= cnt_nxt;
        end
    end

    assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_key_input_pio.sv
// Self-checking bench for key_input_pio: directed literal checks plus randomized
// pins/bus traffic compared every cycle against a window-based behavioural model.
module tb_key_input_pio;

    localparam int W   = 8;
    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pins_in;
    logic        chipselect, read, write;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    key_input_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .pins_in(pins_in), .chipselect(chipselect),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: two-cycle pin delay, then a level is accepted once the last DEB
    // synchronized samples all differ from the accepted level.
    logic [7:0]  m_s1, m_s2, m_stable, m_edgecap, m_mask;
    logic [31:0] m_rdata;
    logic        m_valid = 1'b0;
    logic [7:0]  hist[$];

    function automatic logic [31:0] reg_value(input logic [1:0] a);
        case (a)
            2'd0:    return {24'b0, m_stable};
            2'd1:    return {24'b0, m_mask};
            2'd2:    return {24'b0, m_edgecap};
            default: return {24'b0, m_s2};
        endcase
    endfunction

    always @(posedge clk) begin
        logic [7:0] ns, clr;
        bit         flip;
        if (!rst) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0; m_edgecap = 0; m_mask = 0; m_rdata = 0;
            hist.delete();
            repeat (DEB) hist.push_back(8'h00);
            m_valid = 1'b1;
        end else begin
            m_rdata = (chipselect && read) ? reg_value(address) : 32'h0;
            hist.push_back(m_s2);
            void'(hist.pop_front());
            ns = m_stable;
            for (int b = 0; b < 8; b++) begin
                flip = 1'b1;
                foreach (hist[k]) if (hist[k][b] == m_stable[b]) flip = 1'b0;
                if (flip) ns[b] = ~m_stable[b];
            end
            clr = (chipselect && write && address == 2'd2) ? writedata[7:0] : 8'h00;
            m_edgecap = (m_edgecap & ~clr) | (ns & ~m_stable);
            if (chipselect && write && address == 2'd1) m_mask = writedata[7:0];
            m_stable = ns;
            m_s2 = m_s1;
            m_s1 = pins_in;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_readdata", readdata, m_rdata);
            check("model_irq", {31'b0, irq}, {31'b0, |(m_edgecap & m_mask)});
        end
    end

    task automatic bus(input logic cs, input logic rd, input logic wr,
                       input logic [1:0] a, input logic [31:0] wd);
        chipselect = cs; read = rd; write = wr; address = a; writedata = wd;
    endtask

    initial begin
        rst = 1'b0; pins_in = 8'h00;
        bus(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Idle reads of every register after reset.
        for (int a = 0; a < 4; a++) begin
            bus(1, 1, 0, 2'(a), 0);
            @(negedge clk);
            check("idle_read", readdata, 32'h0);
            check("idle_irq", {31'b0, irq}, 32'h0);
        end

        // Clean press of 0x05: RAW visible after edge 2, DATA after edge 6.
        pins_in = 8'h05;
        for (int k = 1; k <= 7; k++) begin
            bus(1, 1, 0, (k == 3) ? 2'd3 : 2'd0, 0);
            @(negedge clk);
            if (k == 3) check("raw_after_e2", readdata, 32'h05);
            if (k == 6) check("data_not_yet_e5", readdata, 32'h00);
            if (k == 7) check("data_after_e6", readdata, 32'h05);
        end
        bus(1, 1, 0, 2'd2, 0);
        @(negedge clk);
        check("edgecap_press", readdata, 32'h05);
        check("irq_unmasked", {31'b0, irq}, 32'h0);

        // Interrupt path on bit 2.
        bus(1, 0, 1, 2'd1, 32'h04);
        @(negedge clk);
        check("irq_mask_set", {31'b0, irq}, 32'h1);
        bus(1, 0, 1, 2'd2, 32'h01);
        @(negedge clk);
        check("irq_other_clear", {31'b0, irq}, 32'h1);
        bus(1, 1, 0, 2'd2, 0);
        @(negedge clk);
        check("edgecap_bit2_only", readdata, 32'h04);
        bus(1, 0, 1, 2'd2, 32'h04);
        @(negedge clk);
        check("irq_cleared", {31'b0, irq}, 32'h0);

        // Release: no new captures.
        bus(0, 0, 0, 0, 0);
        pins_in = 8'h00;
        repeat (8) @(negedge clk);
        bus(1, 1, 0, 2'd2, 0);
        @(negedge clk);
        check("release_no_edge", readdata, 32'h00);
        bus(1, 1, 0, 2'd0, 0);
        @(negedge clk);
        check("release_data", readdata, 32'h00);

        // Set beats clear: W1C of bit 0 on the edge bit 0 becomes stable high.
        bus(0, 0, 0, 0, 0);
        pins_in = 8'h01;
        repeat (5) @(negedge clk);
        bus(1, 0, 1, 2'd2, 32'h01);
        @(negedge clk);
        bus(1, 1, 0, 2'd2, 0);
        @(negedge clk);
        check("set_beats_clear", readdata, 32'h01);

        // Reset in the middle of a bit-1 debounce.
        bus(0, 0, 0, 0, 0);
        pins_in = 8'h03;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus(1, 1, 0, 2'd2, 0);
        @(negedge clk);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_readdata", readdata, 32'h0);
        rst = 1'b1;
        for (int a = 0; a < 3; a++) begin
            bus(1, 1, 0, 2'(a), 0);
            @(negedge clk);
            check("post_reset_read", readdata, 32'h0);
        end

        // Randomized pins with bounce, bus traffic and rare resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) pins_in = 8'($urandom);
            else if ($urandom_range(0, 9) == 0) pins_in = pins_in ^ 8'(1 << $urandom_range(0, 7));
            bus($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0,
                2'($urandom), (($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'hFFFF_FF00 | 32'($urandom_range(0, 255))));
            rst = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_input_pio.md
Name: key_input_pio

Overview:
- Avalon-MM slave input port: the read-side counterpart of the LED output PIO in the Nios II system.
- Samples WIDTH asynchronous switch/key pins, synchronizes and debounces each bit, and latches rising edges.
- Raises a maskable level interrupt so software can poll or take IRQs for board inputs.
- Instantiated at top level beside the CPU system and connected through its exported slave conduit.

Parameters:
- WIDTH, 8, number of input pins (1..32).
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a level change (10 ms at 50 MHz); minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-low reset; clears state on a clk edge where rst==0.
- pins_in  input  WIDTH  raw asynchronous board inputs.
- chipselect  input  1  slave select.
- address  input  2  register word address.
- read  input  1  read strobe; valid only with chipselect.
- write  input  1  write strobe; valid only with chipselect.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- irq  output  1  level interrupt to the CPU.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Synchronizer flops, stable levels, debounce counters, EDGECAP and IRQMASK all go to 0.
  - readdata=0; irq=0.
- Synchronizer:
  - Two flops per bit: sync1<=pins_in, sync2<=sync1.
  - No logic between the two flops.
- Debounce, per bit, using an independent counter of width clog2(DEBOUNCE_CYCLES) (minimum 1 bit):
  - If sync2==stable: counter<=0.
  - Else, if counter==DEBOUNCE_CYCLES-1: stable<=sync2 and counter<=0.
  - Else: counter<=counter+1.
  - Any glitch back to the stable value restarts the count.
  - Pin-to-stable latency is exactly DEBOUNCE_CYCLES+2 clk edges.
- Edge capture:
  - On the same edge where stable goes 0->1, the EDGECAP bit is set.
  - 1->0 transitions are not captured.
  - Bits stay set until cleared by software.
- Register map (32-bit; bits above WIDTH read 0):
  - addr 0 DATA: read returns stable levels; writes ignored.
  - addr 1 IRQMASK: read/write, bits [WIDTH-1:0].
  - addr 2 EDGECAP: read returns captured bits; a write clears every bit where writedata is 1 (W1C).
  - addr 3 RAW: read returns sync2, undebounced, for debug; writes ignored.
- Read timing:
  - Fixed read latency of 1.
  - When chipselect&read is sampled at edge N, readdata holds the addressed value from before edge N, valid after edge N.
  - After any edge without a read, readdata<=0.
- Write timing:
  - A write takes effect at the sampling edge and is visible to a read issued in the next cycle.
  - read and write asserted together: both are performed; readdata returns the pre-write value.
- Interrupt:
  - irq = |(EDGECAP & IRQMASK), combinational from registers.
  - irq rises in the same cycle the EDGECAP or IRQMASK register updates.
  - irq drops in the cycle after the clearing write edge.
- Simultaneous events: if a W1C clears a bit on the same edge a new rising edge sets it, the set wins and the bit stays 1.
- Post-reset pins: a pin already high at reset deassertion is debounced as a 0->1 change. It sets EDGECAP DEBOUNCE_CYCLES+2 edges after the first edge with rst==1.
- Mid-operation reset: a reset during an in-progress debounce discards the count. The stable value returns to 0 with no edge captured on that reset edge.
- chipselect==0: read and write are ignored, and readdata<=0 at the next edge.

Test Plan (WIDTH=8, DEBOUNCE_CYCLES=4):
- Reset then idle, pins_in=0x00; read addr 0,1,2,3 -> readdata 0x0 each, one cycle after each read; irq=0.
- Clean press: pins_in 0x00->0x05 before edge 1 -> DATA=0x05 after edge 6 (not 5); EDGECAP=0x05 after edge 6; RAW=0x05 after edge 2.
- Bounce rejection: bit0 high for 3 cycles, low 1 cycle, high 4 cycles -> DATA bit0 stays 0 until the 4th consecutive high sync2 cycle; exactly one EDGECAP set.
- Interrupt path, bit2 captured: write IRQMASK=0x04 -> irq=1 the following cycle; write EDGECAP=0x04 -> irq=0 after that edge; write EDGECAP=0x01 -> no effect on bit2.
- Set-beats-clear: time a W1C of 0x01 to coincide with the stable 0->1 edge of bit0 -> EDGECAP bit0 reads 1 afterwards.
- Release and reset: pins 0x05->0x00 -> DATA=0x00 after 6 edges with no new EDGECAP bits; assert rst mid-debounce -> all registers 0 and irq=0 on the next edge.
